// File: rtl/prog_loader_if.sv
// Byte-stream and instruction-memory write bus between a program source and prog_loader.
// The loader uses the slave side; the source/observer uses the master side.
interface prog_loader_if #(
  parameter int AW = 6
) ();
  // A byte moves on any rising edge where byte_valid && byte_ready; byte_ready
  // never looks at byte_valid, and byte_data must be held while valid waits.
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory
// and holds the processor in reset until a session completes cleanly.
module prog_loader #(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  prog_loader_if.slave bus,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t      state_q, state_d;
  logic        xfer, start_ok, last_word;
  logic [15:0] n_in;
  logic [15:0] len_q, word_cnt_q;
  logic [7:0]  len_lo_q, acc_q;
  logic [1:0]  byte_cnt_q;
  logic [23:0] shift_q;

  assign bus.byte_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                          (state_q == S_DATA)   || (state_q == S_CSUM);
  assign xfer      = bus.byte_valid && bus.byte_ready;
  assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                               (state_q == S_ERR));
  assign n_in      = {bus.byte_data, len_lo_q};
  assign last_word = (word_cnt_q + 16'd1) == len_q;
  // The final word's write strobe lands while already in CSUM/DONE/ERR.
  assign busy      = bus.byte_ready || bus.imem_we;
  assign state     = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_LEN_LO;
      S_LEN_LO: if (xfer) state_d = S_LEN_HI;
      S_LEN_HI: begin
        if (xfer) begin
          if ({1'b0, n_in} > DEPTH_W) state_d = S_ERR;
          else if (n_in == 16'd0)     state_d = S_CSUM;
          else                        state_d = S_DATA;
        end
      end
      S_DATA: if (xfer && (byte_cnt_q == 2'd3) && last_word) state_d = S_CSUM;
      S_CSUM: begin
        if (xfer) state_d = (bus.byte_data == acc_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q          <= '0;
      len_lo_q       <= '0;
      word_cnt_q     <= '0;
      byte_cnt_q     <= '0;
      acc_q          <= '0;
      shift_q        <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      done           <= 1'b0;
      error          <= 1'b0;
      cpu_rst        <= 1'b1;
    end else begin
      bus.imem_we <= 1'b0;
      done        <= 1'b0;
      if (start_ok) begin
        word_cnt_q <= '0;
        byte_cnt_q <= '0;
        acc_q      <= '0;
        error      <= 1'b0;
        cpu_rst    <= 1'b1;
      end
      if (xfer) begin
        case (state_q)
          S_LEN_LO: len_lo_q <= bus.byte_data;
          S_LEN_HI: len_q    <= n_in;
          S_DATA: begin
            acc_q      <= acc_q ^ bus.byte_data;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            shift_q    <= {bus.byte_data, shift_q[23:8]};
            // Fourth byte completes the word: first arrival ends up in the low byte.
            if (byte_cnt_q == 2'd3) begin
              bus.imem_we    <= 1'b1;
              bus.imem_addr  <= word_cnt_q[AW-1:0];
              bus.imem_wdata <= {bus.byte_data, shift_q};
              word_cnt_q     <= word_cnt_q + 16'd1;
            end
          end
          default: ;
        endcase
      end
      if ((state_d == S_DONE) && (state_q != S_DONE)) begin
        done    <= 1'b1;
        cpu_rst <= 1'b0;
      end
      if ((state_d == S_ERR) && (state_q != S_ERR)) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed streams plus randomized sessions against a
// stream-parsing reference model.
module tb_prog_loader;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cpu_rst, busy, done, error;
  logic [2:0] state;

  prog_loader_if #(.AW(AW)) bus ();

  prog_loader #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus),
    .cpu_rst (cpu_rst),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .state   (state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]       stm_q[$];
  logic [AW+31:0]   exp_q[$];
  logic [AW+31:0]   obs_q[$];
  int               done_cnt;
  bit               exp_ok;
  int               exp_nsend;
  int               exp_n;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.imem_we) obs_q.push_back({bus.imem_addr, bus.imem_wdata});
    if (done) done_cnt++;
  end

  // Reference: parse the stream by its format rules into expected writes and outcome.
  task automatic model();
    logic [7:0] x;
    exp_q.delete();
    exp_n = int'(stm_q[0]) + 256 * int'(stm_q[1]);
    if (exp_n > DEPTH) begin
      exp_ok = 1'b0;
      exp_nsend = 2;
      return;
    end
    x = 8'h00;
    for (int k = 0; k < exp_n; k++) begin
      logic [7:0] b0, b1, b2, b3;
      b0 = stm_q[2 + 4*k];
      b1 = stm_q[3 + 4*k];
      b2 = stm_q[4 + 4*k];
      b3 = stm_q[5 + 4*k];
      exp_q.push_back({AW'(k), b3, b2, b1, b0});
      x = x ^ b0 ^ b1 ^ b2 ^ b3;
    end
    exp_nsend = 3 + 4 * exp_n;
    exp_ok = (stm_q[2 + 4*exp_n] == x);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall, input bit noise, output bit ok);
    int guard;
    if (stall) begin
      guard = 0;
      while ($urandom_range(0, 1) == 1 && guard < 8) begin
        bus.byte_valid = 1'b0;
        if (noise) start = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        guard++;
      end
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    if (noise) start = 1'($urandom_range(0, 1));
    guard = 0;
    while (!bus.byte_ready && guard < 64) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!bus.byte_ready) begin
      check("ready_timeout", 64'd0, 64'd1);
      bus.byte_valid = 1'b0;
      start = 1'b0;
      ok = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
    start = 1'b0;
    ok = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_session(input bit stall, input bit noise);
    bit ok;
    model();
    obs_q.delete();
    done_cnt = 0;
    pulse_start();
    check("start_cpu_rst", 64'(cpu_rst), 64'd1);
    check("start_error", 64'(error), 64'd0);
    check("start_busy", 64'(busy), 64'd1);
    for (int i = 0; i < exp_nsend; i++) begin
      send_byte(stm_q[i], stall, noise, ok);
      if (!ok) break;
      if (i >= 2 && i < 2 + 4*exp_n && ((i - 2) % 4) == 3) begin
        check("we_after_4th", 64'(bus.imem_we), 64'd1);
        check("we_addr", 64'(bus.imem_addr), 64'(exp_q[(i-2)/4][AW+31:32]));
        check("we_data", 64'(bus.imem_wdata), 64'(exp_q[(i-2)/4][31:0]));
      end else begin
        check("we_idle", 64'(bus.imem_we), 64'd0);
      end
    end
    check("end_done", 64'(done), 64'(exp_ok));
    check("end_error", 64'(error), 64'(!exp_ok));
    check("end_cpu_rst", 64'(cpu_rst), 64'(!exp_ok));
    check("end_ready", 64'(bus.byte_ready), 64'd0);
    check("end_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("write_count", 64'(obs_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
      check("write_entry", 64'(obs_q[k]), 64'(exp_q[k]));
    check("done_count", 64'(done_cnt), 64'(exp_ok));
  endtask

  task automatic load_base(input logic [7:0] csum);
    logic [7:0] base [10];
    base = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'h30, 8'h00};
    stm_q.delete();
    for (int i = 0; i < 10; i++) stm_q.push_back(base[i]);
    stm_q.push_back(csum);
  endtask

  task automatic load_random(input int n, input bit corrupt);
    logic [7:0] x, b;
    stm_q.delete();
    stm_q.push_back(8'(n));
    stm_q.push_back(8'(n >> 8));
    x = 8'h00;
    for (int i = 0; i < 4*n; i++) begin
      b = 8'($urandom_range(0, 255));
      stm_q.push_back(b);
      x = x ^ b;
    end
    if (corrupt) x = x ^ 8'($urandom_range(1, 255));
    stm_q.push_back(x);
  endtask

  initial begin
    bit ok;
    rst = 1'b1;
    start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    done_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 64'(state), 64'd0);
    check("rst_ready", 64'(bus.byte_ready), 64'd0);
    check("rst_we", 64'(bus.imem_we), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reference two-word program, then the same with stalls.
    load_base(8'hE0);
    run_session(1'b0, 1'b0);
    run_session(1'b1, 1'b0);

    // Oversized length is rejected right after the length bytes.
    stm_q.delete();
    stm_q.push_back(8'h41);
    stm_q.push_back(8'h00);
    run_session(1'b0, 1'b0);

    // Bad checksum keeps the written words but flags error; a new start clears it.
    load_base(8'hFF);
    run_session(1'b0, 1'b0);
    pulse_start();
    check("restart_clears_error", 64'(error), 64'd0);
    check("restart_cpu_rst", 64'(cpu_rst), 64'd1);

    // Empty program completes directly through the checksum byte.
    stm_q.delete();
    stm_q.push_back(8'h00);
    stm_q.push_back(8'h00);
    stm_q.push_back(8'h00);
    run_session(1'b0, 1'b0);

    // Full-depth program is accepted.
    load_random(DEPTH, 1'b0);
    run_session(1'b0, 1'b0);

    // Reset mid-session after five data bytes.
    load_base(8'hE0);
    obs_q.delete();
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(stm_q[i], 1'b0, 1'b0, ok);
    rst = 1'b1;
    #1;
    check("mid_rst_state", 64'(state), 64'd0);
    check("mid_rst_ready", 64'(bus.byte_ready), 64'd0);
    check("mid_rst_we", 64'(bus.imem_we), 64'd0);
    check("mid_rst_addr", 64'(bus.imem_addr), 64'd0);
    check("mid_rst_wdata", 64'(bus.imem_wdata), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_error", 64'(error), 64'd0);
    check("mid_rst_cpu_rst", 64'(cpu_rst), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_writes", 64'(obs_q.size()), 64'd1);
    run_session(1'b0, 1'b0);

    // Randomized sessions with stalls and start toggling while busy.
    for (int s = 0; s < 12; s++) begin
      load_random($urandom_range(0, 6), $urandom_range(0, 3) == 0);
      run_session(1'b1, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
